// File: rtl/triangle_raster_engine.sv
// Triangle raster engine: scans each table triangle's screen-clamped bounding box
// one candidate per cycle and streams covered pixel addresses over valid/ready.
module triangle_raster_engine #(
  parameter int RENDERING_WIDTH  = 320,
  parameter int RENDERING_HEIGHT = 240,
  parameter int MAX_NUM_TRIANGLE = 32,
  parameter int COORD_WIDTH      = 11,
  parameter int COLOR_WIDTH      = 3
) (
  input  logic                                aClock,
  input  logic                                aResetN,
  input  logic                                aLoadValid,
  input  logic [$clog2(MAX_NUM_TRIANGLE)-1:0] aLoadIndex,
  input  logic [COORD_WIDTH-1:0]              aLoadX0,
  input  logic [COORD_WIDTH-1:0]              aLoadY0,
  input  logic [COORD_WIDTH-1:0]              aLoadX1,
  input  logic [COORD_WIDTH-1:0]              aLoadY1,
  input  logic [COORD_WIDTH-1:0]              aLoadX2,
  input  logic [COORD_WIDTH-1:0]              aLoadY2,
  input  logic [COLOR_WIDTH-1:0]              aLoadColor,
  input  logic [$clog2(MAX_NUM_TRIANGLE):0]   aTriangleCount,
  input  logic                                aFrameFlipped,
  input  logic                                aPixelReady,
  output logic                                anOutPixelValid,
  output logic [31:0]                         anOutPixelAddr,
  output logic [COLOR_WIDTH-1:0]              anOutPixelData,
  output logic                                anOutBusy,
  output logic                                anOutFrameDone
);

  localparam int INDEX_WIDTH = $clog2(MAX_NUM_TRIANGLE);
  localparam int COUNT_WIDTH = INDEX_WIDTH + 1;
  localparam int EDGE_WIDTH  = 2 * COORD_WIDTH + 2;

  localparam logic [COORD_WIDTH:0]   WIDTH_LIMIT  = (COORD_WIDTH + 1)'(RENDERING_WIDTH);
  localparam logic [COORD_WIDTH:0]   HEIGHT_LIMIT = (COORD_WIDTH + 1)'(RENDERING_HEIGHT);
  localparam logic [COORD_WIDTH-1:0] LAST_X       = COORD_WIDTH'(RENDERING_WIDTH - 1);
  localparam logic [COORD_WIDTH-1:0] LAST_Y       = COORD_WIDTH'(RENDERING_HEIGHT - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_LIMIT  = COUNT_WIDTH'(MAX_NUM_TRIANGLE);
  localparam logic [31:0]            PITCH        = 32'(RENDERING_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, RASTER, DRAIN} state_t;

  typedef struct packed {
    logic [COORD_WIDTH-1:0] x0;
    logic [COORD_WIDTH-1:0] y0;
    logic [COORD_WIDTH-1:0] x1;
    logic [COORD_WIDTH-1:0] y1;
    logic [COORD_WIDTH-1:0] x2;
    logic [COORD_WIDTH-1:0] y2;
    logic [COLOR_WIDTH-1:0] color;
  } triangle_t;

  function automatic logic [COORD_WIDTH-1:0] min3(input logic [COORD_WIDTH-1:0] a, b, c);
    logic [COORD_WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic logic [COORD_WIDTH-1:0] max3(input logic [COORD_WIDTH-1:0] a, b, c);
    logic [COORD_WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Cross product (b-a) x (p-a); its sign tells which side of edge a->b p lies on.
  function automatic logic signed [EDGE_WIDTH-1:0] edgeFn(
    input logic [COORD_WIDTH-1:0] ax, ay, bx, by, px, py
  );
    logic signed [EDGE_WIDTH-1:0] dxAB, dyAB, dxAP, dyAP;
    dxAB = $signed(EDGE_WIDTH'(bx)) - $signed(EDGE_WIDTH'(ax));
    dyAB = $signed(EDGE_WIDTH'(by)) - $signed(EDGE_WIDTH'(ay));
    dxAP = $signed(EDGE_WIDTH'(px)) - $signed(EDGE_WIDTH'(ax));
    dyAP = $signed(EDGE_WIDTH'(py)) - $signed(EDGE_WIDTH'(ay));
    return dxAB * dyAP - dyAB * dxAP;
  endfunction

  state_t                 state, nextState;
  triangle_t              triangleTable [MAX_NUM_TRIANGLE];
  triangle_t              activeTri;
  logic [INDEX_WIDTH-1:0] triangleIndex;
  logic [COUNT_WIDTH-1:0] countLatched;
  logic [COORD_WIDTH-1:0] posX, posY;
  logic [COORD_WIDTH-1:0] bbMinX, bbMaxX, bbMaxY;

  // NOTE: the table is plain storage with no reset so it can map onto a RAM.
  always_ff @(posedge aClock) begin
    if (state == IDLE && aLoadValid) begin
      triangleTable[aLoadIndex] <= '{x0: aLoadX0, y0: aLoadY0, x1: aLoadX1, y1: aLoadY1,
                                     x2: aLoadX2, y2: aLoadY2, color: aLoadColor};
    end
  end

  triangle_t                    setupTri;
  logic [COORD_WIDTH-1:0]       setupMinX, setupMinY, setupMaxX, setupMaxY;
  logic signed [EDGE_WIDTH-1:0] setupArea;
  logic                         setupSkip;

  assign setupTri = triangleTable[triangleIndex];

  always_comb begin
    setupMinX = min3(setupTri.x0, setupTri.x1, setupTri.x2);
    setupMinY = min3(setupTri.y0, setupTri.y1, setupTri.y2);
    setupMaxX = max3(setupTri.x0, setupTri.x1, setupTri.x2);
    setupMaxY = max3(setupTri.y0, setupTri.y1, setupTri.y2);
    if (setupMaxX > LAST_X) setupMaxX = LAST_X;
    if (setupMaxY > LAST_Y) setupMaxY = LAST_Y;
    setupArea = edgeFn(setupTri.x0, setupTri.y0, setupTri.x1, setupTri.y1,
                       setupTri.x2, setupTri.y2);
    setupSkip = (setupArea == '0) || ({1'b0, setupMinX} >= WIDTH_LIMIT)
             || ({1'b0, setupMinY} >= HEIGHT_LIMIT);
  end

  logic signed [EDGE_WIDTH-1:0] edge0, edge1, edge2;
  logic                         candidateInside;
  logic [31:0]                  candidateAddr;
  logic                         stall, advance, lastCandidate, lastTriangle;
  logic [COUNT_WIDTH-1:0]       clampedCount;

  always_comb begin
    edge0 = edgeFn(activeTri.x0, activeTri.y0, activeTri.x1, activeTri.y1, posX, posY);
    edge1 = edgeFn(activeTri.x1, activeTri.y1, activeTri.x2, activeTri.y2, posX, posY);
    edge2 = edgeFn(activeTri.x2, activeTri.y2, activeTri.x0, activeTri.y0, posX, posY);
    // Accept either winding; zero on an edge counts as inside for both tests.
    candidateInside = (!edge0[EDGE_WIDTH-1] && !edge1[EDGE_WIDTH-1] && !edge2[EDGE_WIDTH-1])
                   || ((edge0[EDGE_WIDTH-1] || edge0 == '0)
                    && (edge1[EDGE_WIDTH-1] || edge1 == '0)
                    && (edge2[EDGE_WIDTH-1] || edge2 == '0));
  end

  assign candidateAddr = 32'(posY) * PITCH + 32'(posX);
  assign stall         = anOutPixelValid && !aPixelReady;
  assign advance       = (state == RASTER) && !stall;
  assign lastCandidate = (posX == bbMaxX) && (posY == bbMaxY);
  assign lastTriangle  = ({1'b0, triangleIndex} == countLatched - COUNT_WIDTH'(1));
  assign clampedCount  = (aTriangleCount > COUNT_LIMIT) ? COUNT_LIMIT : aTriangleCount;
  assign anOutBusy     = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) state <= IDLE;
    else          state <= nextState;
  end

  // NOTE: nextState gets its default before the case so no path infers a latch.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (aFrameFlipped) nextState = (clampedCount == '0) ? DRAIN : SETUP;
      SETUP:   if (setupSkip) nextState = lastTriangle ? DRAIN : SETUP;
               else           nextState = RASTER;
      RASTER:  if (advance && lastCandidate) nextState = lastTriangle ? DRAIN : SETUP;
      DRAIN:   if (!anOutPixelValid) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) begin
      triangleIndex  <= '0;
      countLatched   <= '0;
      posX           <= '0;
      posY           <= '0;
      bbMinX         <= '0;
      bbMaxX         <= '0;
      bbMaxY         <= '0;
      activeTri      <= '0;
      anOutFrameDone <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aFrameFlipped) begin
            anOutFrameDone <= 1'b0;
            countLatched   <= clampedCount;
            triangleIndex  <= '0;
          end
        end
        SETUP: begin
          if (setupSkip) begin
            triangleIndex <= triangleIndex + INDEX_WIDTH'(1);
          end else begin
            activeTri <= setupTri;
            bbMinX    <= setupMinX;
            bbMaxX    <= setupMaxX;
            bbMaxY    <= setupMaxY;
            posX      <= setupMinX;
            posY      <= setupMinY;
          end
        end
        RASTER: begin
          if (advance) begin
            if (posX == bbMaxX) begin
              posX <= bbMinX;
              if (posY == bbMaxY) triangleIndex <= triangleIndex + INDEX_WIDTH'(1);
              else                posY <= posY + COORD_WIDTH'(1);
            end else begin
              posX <= posX + COORD_WIDTH'(1);
            end
          end
        end
        DRAIN: begin
          if (!anOutPixelValid) anOutFrameDone <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Output register: holds while stalled, otherwise reloads (or empties) every cycle.
  always_ff @(posedge aClock or negedge aResetN) begin
    if (!aResetN) begin
      anOutPixelValid <= 1'b0;
      anOutPixelAddr  <= '0;
      anOutPixelData  <= '0;
    end else if (!stall) begin
      anOutPixelValid <= advance && candidateInside;
      if (advance && candidateInside) begin
        anOutPixelAddr <= candidateAddr;
        anOutPixelData <= activeTri.color;
      end
    end
  end

endmodule

// File: tb/tb_triangle_raster_engine.sv
// Self-checking bench: a bounding-box/edge-function model builds each frame's
// expected pixel stream, and one negedge process compares every transfer against it.
module tb_triangle_raster_engine;

  localparam int W       = 320;
  localparam int H       = 240;
  localparam int MAXT    = 32;
  localparam int TIMEOUT = 20000;

  logic        aClock = 1'b0;
  logic        aResetN = 1'b1;
  logic        aLoadValid = 1'b0;
  logic [4:0]  aLoadIndex = '0;
  logic [10:0] aLoadX0 = '0, aLoadY0 = '0, aLoadX1 = '0, aLoadY1 = '0, aLoadX2 = '0, aLoadY2 = '0;
  logic [2:0]  aLoadColor = '0;
  logic [5:0]  aTriangleCount = '0;
  logic        aFrameFlipped = 1'b0;
  logic        aPixelReady = 1'b1;
  logic        anOutPixelValid;
  logic [31:0] anOutPixelAddr;
  logic [2:0]  anOutPixelData;
  logic        anOutBusy;
  logic        anOutFrameDone;

  always #5 aClock = ~aClock;

  triangle_raster_engine #(
    .RENDERING_WIDTH(W), .RENDERING_HEIGHT(H), .MAX_NUM_TRIANGLE(MAXT),
    .COORD_WIDTH(11), .COLOR_WIDTH(3)
  ) dut (
    .aClock(aClock), .aResetN(aResetN),
    .aLoadValid(aLoadValid), .aLoadIndex(aLoadIndex),
    .aLoadX0(aLoadX0), .aLoadY0(aLoadY0), .aLoadX1(aLoadX1),
    .aLoadY1(aLoadY1), .aLoadX2(aLoadX2), .aLoadY2(aLoadY2),
    .aLoadColor(aLoadColor), .aTriangleCount(aTriangleCount),
    .aFrameFlipped(aFrameFlipped), .aPixelReady(aPixelReady),
    .anOutPixelValid(anOutPixelValid), .anOutPixelAddr(anOutPixelAddr),
    .anOutPixelData(anOutPixelData), .anOutBusy(anOutBusy),
    .anOutFrameDone(anOutFrameDone)
  );

  typedef struct { int x0, y0, x1, y1, x2, y2, c; } tri_t;
  typedef struct { int addr; int data; } pix_t;

  tri_t modelTable [MAXT];
  pix_t expQ [$];
  pix_t refQ [$];
  int   total = 0;
  int   bad = 0;
  int   xfers = 0;
  bit   readyRandom = 1'b0;

  string       pendName [$];
  logic [63:0] pendAct [$];
  logic [63:0] pendReq [$];

  int lit32 [10] = '{0, 1, 2, 3, 320, 321, 322, 640, 641, 960};
  int lit34 [11] = '{318, 319, 638, 639, 958, 959, 1278, 1279, 1598, 1599, 1918};

  // Main-process checks are queued and evaluated by the compare process.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    pendName.push_back(name);
    pendAct.push_back(act);
    pendReq.push_back(req);
  endtask

  task automatic compare(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic tri_t mkTri(input int x0, y0, x1, y1, x2, y2, c);
    tri_t t;
    t.x0 = x0; t.y0 = y0; t.x1 = x1; t.y1 = y1; t.x2 = x2; t.y2 = y2; t.c = c;
    return t;
  endfunction

  function automatic tri_t randTri();
    int bx = int'($urandom_range(0, 345));
    int by = int'($urandom_range(0, 255));
    int c  = int'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) return mkTri(bx, by, bx + 1, by + 1, bx + 2, by + 2, c);
    return mkTri(bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                 bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                 bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)), c);
  endfunction

  function automatic longint edgeOf(input int ax, ay, bx, by, px, py);
    return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
  endfunction

  function automatic int min3i(input int a, b, c);
    int m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic int max3i(input int a, b, c);
    int m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Expected stream: table order, then row by row, left to right, inside the clipped box.
  function automatic void buildExpected(input int cnt);
    tri_t   t;
    pix_t   p;
    int     n, mnx, mny, mxx, mxy;
    longint e0, e1, e2;
    n = (cnt > MAXT) ? MAXT : cnt;
    for (int i = 0; i < n; i++) begin
      t = modelTable[i];
      if (edgeOf(t.x0, t.y0, t.x1, t.y1, t.x2, t.y2) == 0) continue;
      mnx = min3i(t.x0, t.x1, t.x2);
      mny = min3i(t.y0, t.y1, t.y2);
      mxx = max3i(t.x0, t.x1, t.x2);
      mxy = max3i(t.y0, t.y1, t.y2);
      if (mnx >= W || mny >= H) continue;
      if (mxx > W - 1) mxx = W - 1;
      if (mxy > H - 1) mxy = H - 1;
      for (int y = mny; y <= mxy; y++) begin
        for (int x = mnx; x <= mxx; x++) begin
          e0 = edgeOf(t.x0, t.y0, t.x1, t.y1, x, y);
          e1 = edgeOf(t.x1, t.y1, t.x2, t.y2, x, y);
          e2 = edgeOf(t.x2, t.y2, t.x0, t.y0, x, y);
          if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
            p.addr = y * W + x;
            p.data = t.c;
            expQ.push_back(p);
          end
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge aClock);
    #1;
    if (readyRandom) aPixelReady = ($urandom_range(0, 9) < 7);
  endtask

  task automatic driveLoad(input int idx, input tri_t t);
    aLoadValid = 1'b1;
    aLoadIndex = 5'(idx);
    aLoadX0 = 11'(t.x0); aLoadY0 = 11'(t.y0);
    aLoadX1 = 11'(t.x1); aLoadY1 = 11'(t.y1);
    aLoadX2 = 11'(t.x2); aLoadY2 = 11'(t.y2);
    aLoadColor = 3'(t.c);
  endtask

  task automatic loadTri(input int idx, input tri_t t);
    driveLoad(idx, t);
    modelTable[idx] = t;
    tick();
    aLoadValid = 1'b0;
  endtask

  task automatic startFrame(input int cnt);
    buildExpected(cnt);
    aTriangleCount = 6'(cnt);
    aFrameFlipped = 1'b1;
    tick();
    aFrameFlipped = 1'b0;
    aLoadValid = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = 0;
    while (!anOutFrameDone && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    check("frame done", anOutFrameDone, 1);
    check("pixels outstanding", expQ.size(), 0);
  endtask

  // Compare process: every accepted pixel against the model, and stalled outputs held.
  logic        holdPending = 1'b0;
  logic [31:0] holdAddr = '0;
  logic [2:0]  holdData = '0;
  pix_t        popped;

  always @(negedge aClock) begin
    while (pendName.size() > 0) compare(pendName.pop_front(), pendAct.pop_front(), pendReq.pop_front());
    if (!aResetN) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        compare("hold valid", anOutPixelValid, 1);
        compare("hold addr", anOutPixelAddr, holdAddr);
        compare("hold data", anOutPixelData, holdData);
      end
      if (anOutPixelValid && aPixelReady) begin
        compare("pixel expected", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          popped = expQ.pop_front();
          compare("pixel addr", anOutPixelAddr, popped.addr);
          compare("pixel data", anOutPixelData, popped.data);
        end
        xfers++;
      end
      holdPending = anOutPixelValid && !aPixelReady;
      holdAddr    = anOutPixelAddr;
      holdData    = anOutPixelData;
    end
  end

  initial begin
    int   cyc;
    int   startXfers;
    tri_t big;

    #2 aResetN = 1'b0;
    repeat (3) tick();
    check("reset valid", anOutPixelValid, 0);
    check("reset addr", anOutPixelAddr, 0);
    check("reset data", anOutPixelData, 0);
    check("reset busy", anOutBusy, 0);
    check("reset done", anOutFrameDone, 0);
    aResetN = 1'b1;
    tick();
    for (int i = 0; i < MAXT; i++) loadTri(i, randTri());

    // Small right triangle: model pinned to hand-derived addresses, then latency checked.
    loadTri(0, mkTri(0, 0, 3, 0, 0, 3, 5));
    buildExpected(1);
    check("model tri count", expQ.size(), 10);
    for (int k = 0; k < 10; k++) check("model tri addr", expQ[k].addr, lit32[k]);
    refQ = expQ;
    expQ.delete();
    startXfers = xfers;
    startFrame(1);
    check("flip busy", anOutBusy, 1);
    check("flip clears done", anOutFrameDone, 0);
    check("latency N+1 valid", anOutPixelValid, 0);
    tick();
    check("latency N+2 valid", anOutPixelValid, 0);
    tick();
    check("latency N+3 valid", anOutPixelValid, 1);
    check("first addr", anOutPixelAddr, 0);
    check("first data", anOutPixelData, 5);
    waitDone(cyc);
    check("tri transfers", xfers - startXfers, 10);
    check("idle after frame", anOutBusy, 0);

    // Opposite winding of the same triangle.
    loadTri(0, mkTri(0, 0, 0, 3, 3, 0, 5));
    buildExpected(1);
    check("cw count", expQ.size(), refQ.size());
    for (int k = 0; k < expQ.size() && k < refQ.size(); k++) check("cw addr", expQ[k].addr, refQ[k].addr);
    expQ.delete();
    startXfers = xfers;
    startFrame(1);
    waitDone(cyc);
    check("cw transfers", xfers - startXfers, 10);

    // Triangle crossing the right screen edge, random backpressure.
    loadTri(0, mkTri(318, 0, 330, 0, 318, 5, 3));
    buildExpected(1);
    check("clip count", expQ.size(), 11);
    for (int k = 0; k < expQ.size() && k < 11; k++) check("clip addr", expQ[k].addr, lit34[k]);
    expQ.delete();
    readyRandom = 1'b1;
    startFrame(1);
    waitDone(cyc);
    readyRandom = 1'b0;
    aPixelReady = 1'b1;

    // Five-cycle stall mid-stream.
    loadTri(0, mkTri(0, 0, 3, 0, 0, 3, 5));
    startXfers = xfers;
    startFrame(1);
    repeat (4) tick();
    aPixelReady = 1'b0;
    repeat (5) tick();
    check("stall valid", anOutPixelValid, 1);
    aPixelReady = 1'b1;
    waitDone(cyc);
    check("stall transfers", xfers - startXfers, 10);

    // Degenerate triangle, then an empty frame.
    loadTri(0, mkTri(1, 1, 2, 2, 3, 3, 6));
    startXfers = xfers;
    startFrame(1);
    waitDone(cyc);
    check("degenerate transfers", xfers - startXfers, 0);
    startFrame(0);
    waitDone(cyc);
    check("empty frame done within 3", cyc <= 3, 1);
    check("empty frame transfers", xfers - startXfers, 0);

    // Writes and flips while busy must be ignored.
    big = mkTri(0, 0, 20, 0, 0, 20, 2);
    loadTri(0, big);
    startFrame(1);
    repeat (5) tick();
    driveLoad(0, mkTri(100, 100, 150, 100, 100, 150, 7));
    aFrameFlipped = 1'b1;
    tick();
    aLoadValid = 1'b0;
    aFrameFlipped = 1'b0;
    waitDone(cyc);

    // Write and flip in the same idle cycle: the new entry belongs to this frame.
    driveLoad(1, mkTri(10, 10, 14, 10, 10, 14, 4));
    modelTable[1] = mkTri(10, 10, 14, 10, 10, 14, 4);
    startFrame(2);
    waitDone(cyc);

    // Reset mid-raster aborts; the next frame redraws in full.
    startFrame(1);
    repeat (8) tick();
    check("busy before reset", anOutBusy, 1);
    aResetN = 1'b0;
    #1;
    check("abort valid", anOutPixelValid, 0);
    check("abort addr", anOutPixelAddr, 0);
    check("abort data", anOutPixelData, 0);
    check("abort busy", anOutBusy, 0);
    check("abort done", anOutFrameDone, 0);
    expQ.delete();
    tick();
    tick();
    aResetN = 1'b1;
    tick();
    startXfers = xfers;
    startFrame(1);
    waitDone(cyc);
    check("redraw transfers", xfers - startXfers, 231);

    // Randomized frames with random backpressure.
    readyRandom = 1'b1;
    for (int f = 0; f < 8; f++) begin
      int k = int'($urandom_range(1, 4));
      for (int i = 0; i < k; i++) loadTri(i, randTri());
      startFrame(k);
      waitDone(cyc);
    end
    // Count above table depth is clamped to every entry.
    startFrame(63);
    waitDone(cyc);
    readyRandom = 1'b0;
    aPixelReady = 1'b1;

    tick();
    @(negedge aClock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
